issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Issue stage between decode and the two execution lanes.
- Buffers decoded instructions (pc + decode_out) in an in-order circular queue.
- Each cycle, selects up to two instructions for lane 0 (older) and lane 1 (younger).
- Applies load-use, intra-pair RAW, WAW and single-data-port hazard rules; drives registered issue outputs into the lanes.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- DEC_W, 68, decode_out width (`DECODEOUT_BUS).
- PC_W, 32, pc width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard queue contents and issue registers (branch redirect)
- stop  in  1  lanes stalled; hold issue outputs, no dequeue
- in_cnt  in  2  number of valid inputs this cycle: 0, 1 or 2; in0 is older
- in_pc0  in  PC_W  pc of input 0
- in_dec0  in  DEC_W  decode_out of input 0
- in_pc1  in  PC_W  pc of input 1
- in_dec1  in  DEC_W  decode_out of input 1
- in_ready  out  1  free entries ≥2
- iss_v0  out  1  lane 0 valid
- iss_pc0  out  PC_W  lane 0 pc
- iss_dec0  out  DEC_W  lane 0 decode_out
- iss_v1  out  1  lane 1 valid
- iss_pc1  out  PC_W  lane 1 pc
- iss_dec1  out  DEC_W  lane 1 decode_out

Behaviour:
- Reset:
  - Queue empty; count=0; pointers=0.
  - iss_v0=iss_v1=0; iss_pc*=`PC_INITIAL; iss_dec* all zero.
  - in_ready=1; load tracking cleared.
- Enqueue:
  - On the clock edge when in_ready=1, enqueue in_cnt entries, in0 first.
  - Inputs presented while in_ready=0 are ignored; upstream holds them.
  - in_ready is computed from the count before dequeue (conservative).
- Issue selection, combinational from head H and next N:
  - H is issuable if valid and not load-use.
  - Load-use: a lane issued last cycle has RFWe=1, RFWsrc=`RFW_FROM_MEM and rd≠0, and that rd equals H.rs (with rs_v) or H.rt (with rt_v).
  - N is issuable only if all of the following hold:
    - H issues and N is valid.
    - N has no load-use hazard.
    - N does not read H.rd (H.RFWe=1, rd≠0).
    - H.rd≠N.rd when both write.
    - Not both memory ops: load or DMWe.
    - H.NPCop=`NPC_PC4.
- Issue registers:
  - Selected entries are registered on the edge, dequeued, and shown on iss_* the next cycle.
  - Minimum latency from enqueue edge to iss_v high: 2 cycles.
- Stop:
  - When stop=1: iss_* hold, no dequeue, load tracking holds.
  - Enqueue still proceeds if in_ready=1.
- Flush:
  - Flush has priority over stop and enqueue.
  - Next edge: queue empty, iss_v0=iss_v1=0, load tracking cleared, same-cycle inputs dropped.
- Bubbles:
  - If H is not issuable (and stop=0), iss_v0=iss_v1=0 next cycle.
  - Load tracking is cleared after the bubble.
- iss_v1=1 implies iss_v0=1.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Full: in_ready=0 when count>DEPTH-2.
- Empty: iss_v* deassert.
- rst mid-operation: state equals the reset state next cycle.

Optional Feature:
- Macro: ISSUE_DUAL_EN.
- Defined: dual issue as above.
- Undefined:
  - Lane 1 never issues: iss_v1 tied 0, iss_pc1/iss_dec1 zero.
  - Only H selection logic is built; load tracking covers lane 0 only.

Decomposition:
- Add to def.vh:
  - DECODEOUT field bit ranges for rs, rt, rd, rs_v, rt_v, NPCop, DMWe, RFWe, RFWsrc.
  - `RFW_FROM_MEM, `NPC_PC4, `PC_INITIAL.
- One sub-module, issue_hazard:
  - Inputs: H/N decode words plus last-cycle load rd/valid for both lanes.
  - Outputs: issue_h, issue_n.
  - Purely combinational.
- Queue storage and issue registers stay in issue_queue.

Test Plan:
- Reset, then enqueue pair (pc 0x100 addi x1; pc 0x104 addi x2) with no deps → 2 cycles later iss_v0=iss_v1=1, pc0=0x100, pc1=0x104.
- Pair (addi x3; add x4,x3,x5) → cycle A: iss_v0=1 (0x100), iss_v1=0; next cycle iss_v0=1 pc 0x104.
- lw x6 issued, then add x7,x6,x1 at head → one cycle with iss_v0=0, then add issues on lane 0.
- Pair lw/sw → issue on separate cycles. Pair with H=branch (NPCop≠PC4) → lane 1 empty.
- Fill 4 entries with stop=1 → in_ready=0 once count=3, and inputs ignored. Release stop → in_ready returns after dequeue, no entry lost or duplicated; verify pc order through wrap.
- flush with queue count=3 and stop=1 → next cycle iss_v0=iss_v1=0, in_ready=1, and a new entry issues 2 cycles after enqueue.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue stage: decode-word field layout, encodings and
// small field helpers used by the queue and its hazard checker.
package issue_queue_pkg;

    localparam int DEC_FIELD_W = 24;

    localparam int RS_LO     = 0;
    localparam int RT_LO     = 5;
    localparam int RD_LO     = 10;
    localparam int RS_V_BIT  = 15;
    localparam int RT_V_BIT  = 16;
    localparam int NPCOP_LO  = 17;
    localparam int DMWE_BIT  = 20;
    localparam int RFWE_BIT  = 21;
    localparam int RFWSRC_LO = 22;

    typedef enum logic [1:0] {
        RFW_FROM_ALU = 2'd0,
        RFW_FROM_MEM = 2'd1,
        RFW_FROM_PC  = 2'd2,
        RFW_FROM_HI  = 2'd3
    } rfw_src_e;

    localparam logic [2:0]  NPC_PC4    = 3'd0;
    localparam logic [31:0] PC_INITIAL = 32'hBFC0_0000;

    function automatic logic [4:0] dec_rd(input logic [DEC_FIELD_W-1:0] d);
        return d[RD_LO +: 5];
    endfunction

    function automatic logic dec_reads(input logic [DEC_FIELD_W-1:0] d, input logic [4:0] r);
        return (d[RS_V_BIT] && (d[RS_LO +: 5] == r)) || (d[RT_V_BIT] && (d[RT_LO +: 5] == r));
    endfunction

    function automatic logic dec_is_load(input logic [DEC_FIELD_W-1:0] d);
        return d[RFWE_BIT] && (rfw_src_e'(d[RFWSRC_LO +: 2]) == RFW_FROM_MEM);
    endfunction

    function automatic logic dec_is_mem(input logic [DEC_FIELD_W-1:0] d);
        return dec_is_load(d) || d[DMWE_BIT];
    endfunction

endpackage

// File: rtl/issue_queue_hazard.sv
// Combinational issue check for the queue head (H) and the entry behind it (N).
// Lane-1 pairing rules are only built when ISSUE_DUAL_EN is defined.
module issue_hazard
    import issue_queue_pkg::*;
(
    input  logic                   h_v_i,
    input  logic [DEC_FIELD_W-1:0] h_dec_i,
    input  logic                   n_v_i,
    input  logic [DEC_FIELD_W-1:0] n_dec_i,
    input  logic                   ld_v0_i,
    input  logic [4:0]             ld_rd0_i,
    input  logic                   ld_v1_i,
    input  logic [4:0]             ld_rd1_i,
    output logic                   issue_h_o,
    output logic                   issue_n_o
);

    logic h_load_use;

    assign h_load_use = (ld_v0_i && dec_reads(h_dec_i, ld_rd0_i))
                     || (ld_v1_i && dec_reads(h_dec_i, ld_rd1_i));
    assign issue_h_o  = h_v_i && !h_load_use;

`ifdef ISSUE_DUAL_EN
    logic n_load_use;
    logic n_raw;
    logic n_waw;
    logic n_mem;
    logic h_seq;

    assign n_load_use = (ld_v0_i && dec_reads(n_dec_i, ld_rd0_i))
                     || (ld_v1_i && dec_reads(n_dec_i, ld_rd1_i));
    assign n_raw = h_dec_i[RFWE_BIT] && (dec_rd(h_dec_i) != 5'd0)
                && dec_reads(n_dec_i, dec_rd(h_dec_i));
    assign n_waw = h_dec_i[RFWE_BIT] && n_dec_i[RFWE_BIT] && (dec_rd(h_dec_i) == dec_rd(n_dec_i));
    // only one data-memory port is shared by both lanes
    assign n_mem = dec_is_mem(h_dec_i) && dec_is_mem(n_dec_i);
    assign h_seq = (h_dec_i[NPCOP_LO +: 3] == NPC_PC4);

    assign issue_n_o = issue_h_o && n_v_i && !n_load_use && !n_raw && !n_waw && !n_mem && h_seq;
`else
    logic unused_n;

    assign unused_n  = ^{n_v_i, n_dec_i, h_dec_i};
    assign issue_n_o = 1'b0;
`endif

endmodule

// File: rtl/issue_queue.sv
// Issue stage: in-order circular queue of decoded instructions with registered lane outputs.
// Define ISSUE_DUAL_EN for dual issue; otherwise lane 1 is tied off.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DEC_W = 68,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stop,
    input  logic [1:0]       in_cnt,
    input  logic [PC_W-1:0]  in_pc0,
    input  logic [DEC_W-1:0] in_dec0,
    input  logic [PC_W-1:0]  in_pc1,
    input  logic [DEC_W-1:0] in_dec1,
    output logic             in_ready,
    output logic             iss_v0,
    output logic [PC_W-1:0]  iss_pc0,
    output logic [DEC_W-1:0] iss_dec0,
    output logic             iss_v1,
    output logic [PC_W-1:0]  iss_pc1,
    output logic [DEC_W-1:0] iss_dec1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [PC_W-1:0]  pc_mem_q  [DEPTH];
    logic [DEC_W-1:0] dec_mem_q [DEPTH];
    ptr_t             head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             iss_v0_q, iss_v0_d;
    logic [PC_W-1:0]  iss_pc0_q, iss_pc0_d;
    logic [DEC_W-1:0] iss_dec0_q, iss_dec0_d;

    logic [1:0]       enq_n, deq_n;
    logic             h_v, n_v;
    logic [PC_W-1:0]  h_pc;
    logic [DEC_W-1:0] h_dec;
    logic [DEC_FIELD_W-1:0] n_fields;
    logic             issue_h, issue_n;
    logic             ld_v0, ld_v1;
    logic [4:0]       ld_rd0, ld_rd1;

    // readiness looks only at the current count, so it never relies on this cycle's dequeue
    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign enq_n    = !in_ready ? 2'd0 : (in_cnt[1] ? 2'd2 : {1'b0, in_cnt[0]});
    assign deq_n    = stop ? 2'd0 : ({1'b0, issue_h} + {1'b0, issue_n});

    assign h_v   = (count_q != '0);
    assign h_pc  = pc_mem_q[head_q];
    assign h_dec = dec_mem_q[head_q];

    assign ld_rd0 = dec_rd(iss_dec0_q[DEC_FIELD_W-1:0]);
    assign ld_v0  = iss_v0_q && dec_is_load(iss_dec0_q[DEC_FIELD_W-1:0]) && (ld_rd0 != 5'd0);

`ifdef ISSUE_DUAL_EN
    logic             iss_v1_q, iss_v1_d;
    logic [PC_W-1:0]  iss_pc1_q, iss_pc1_d;
    logic [DEC_W-1:0] iss_dec1_q, iss_dec1_d;
    ptr_t             next_p;

    assign next_p   = head_q + ptr_t'(1);
    assign n_v      = (count_q > CNT_W'(1));
    assign n_fields = dec_mem_q[next_p][DEC_FIELD_W-1:0];
    assign ld_rd1   = dec_rd(iss_dec1_q[DEC_FIELD_W-1:0]);
    assign ld_v1    = iss_v1_q && dec_is_load(iss_dec1_q[DEC_FIELD_W-1:0]) && (ld_rd1 != 5'd0);

    assign iss_v1   = iss_v1_q;
    assign iss_pc1  = iss_pc1_q;
    assign iss_dec1 = iss_dec1_q;
`else
    assign n_v      = 1'b0;
    assign n_fields = '0;
    assign ld_rd1   = 5'd0;
    assign ld_v1    = 1'b0;

    assign iss_v1   = 1'b0;
    assign iss_pc1  = '0;
    assign iss_dec1 = '0;
`endif

    issue_hazard u_hazard (
        .h_v_i     (h_v),
        .h_dec_i   (h_dec[DEC_FIELD_W-1:0]),
        .n_v_i     (n_v),
        .n_dec_i   (n_fields),
        .ld_v0_i   (ld_v0),
        .ld_rd0_i  (ld_rd0),
        .ld_v1_i   (ld_v1),
        .ld_rd1_i  (ld_rd1),
        .issue_h_o (issue_h),
        .issue_n_o (issue_n)
    );

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (enq_n != 2'd0) begin
                pc_mem_q[tail_q]  <= in_pc0;
                dec_mem_q[tail_q] <= in_dec0;
            end
            if (enq_n == 2'd2) begin
                pc_mem_q[tail_q + ptr_t'(1)]  <= in_pc1;
                dec_mem_q[tail_q + ptr_t'(1)] <= in_dec1;
            end
        end
    end

    always_comb begin
        head_d  = head_q + ptr_t'(deq_n);
        tail_d  = tail_q + ptr_t'(enq_n);
        count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        iss_v0_d   = iss_v0_q;
        iss_pc0_d  = iss_pc0_q;
        iss_dec0_d = iss_dec0_q;
`ifdef ISSUE_DUAL_EN
        iss_v1_d   = iss_v1_q;
        iss_pc1_d  = iss_pc1_q;
        iss_dec1_d = iss_dec1_q;
`endif
        if (flush) begin
            iss_v0_d = 1'b0;
`ifdef ISSUE_DUAL_EN
            iss_v1_d = 1'b0;
`endif
        end else if (!stop) begin
            iss_v0_d = issue_h;
            if (issue_h) begin
                iss_pc0_d  = h_pc;
                iss_dec0_d = h_dec;
            end
`ifdef ISSUE_DUAL_EN
            iss_v1_d = issue_n;
            if (issue_n) begin
                iss_pc1_d  = pc_mem_q[next_p];
                iss_dec1_d = dec_mem_q[next_p];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            iss_v0_q   <= 1'b0;
            iss_pc0_q  <= PC_W'(PC_INITIAL);
            iss_dec0_q <= '0;
`ifdef ISSUE_DUAL_EN
            iss_v1_q   <= 1'b0;
            iss_pc1_q  <= PC_W'(PC_INITIAL);
            iss_dec1_q <= '0;
`endif
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            iss_v0_q   <= iss_v0_d;
            iss_pc0_q  <= iss_pc0_d;
            iss_dec0_q <= iss_dec0_d;
`ifdef ISSUE_DUAL_EN
            iss_v1_q   <= iss_v1_d;
            iss_pc1_q  <= iss_pc1_d;
            iss_dec1_q <= iss_dec1_d;
`endif
        end
    end

    assign iss_v0   = iss_v0_q;
    assign iss_pc0  = iss_pc0_q;
    assign iss_dec0 = iss_dec0_q;

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: a queue-based reference model predicts every cycle's
// lane outputs and in_ready; a monitor compares them against the DUT mid-cycle.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int DEC_W = 68;
    localparam int PC_W  = 32;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [DEC_W-1:0] dec;
    } entry_t;

    typedef struct {
        logic             v0;
        logic [PC_W-1:0]  pc0;
        logic [DEC_W-1:0] dec0;
        logic             v1;
        logic [PC_W-1:0]  pc1;
        logic [DEC_W-1:0] dec1;
        logic             rdy;
        logic             rchk;
    } exp_t;

    logic             clk;
    logic             rst, flush, stop;
    logic [1:0]       in_cnt;
    logic [PC_W-1:0]  in_pc0, in_pc1;
    logic [DEC_W-1:0] in_dec0, in_dec1;
    logic             in_ready;
    logic             iss_v0, iss_v1;
    logic [PC_W-1:0]  iss_pc0, iss_pc1;
    logic [DEC_W-1:0] iss_dec0, iss_dec1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    entry_t mq[$];
    exp_t   exp_q[$];
    logic             m_v0, m_v1;
    logic [PC_W-1:0]  m_pc0, m_pc1;
    logic [DEC_W-1:0] m_dec0, m_dec1;
    logic [PC_W-1:0]  next_pc = 32'h100;

    issue_queue #(.DEPTH(DEPTH), .DEC_W(DEC_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stop(stop),
        .in_cnt(in_cnt), .in_pc0(in_pc0), .in_dec0(in_dec0), .in_pc1(in_pc1), .in_dec1(in_dec1),
        .in_ready(in_ready),
        .iss_v0(iss_v0), .iss_pc0(iss_pc0), .iss_dec0(iss_dec0),
        .iss_v1(iss_v1), .iss_pc1(iss_pc1), .iss_dec1(iss_dec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DEC_W-1:0] make_dec(input int rs, input int rt, input int rd,
            input bit rs_v, input bit rt_v, input int npc, input bit dmwe, input bit rfwe, input int src);
        logic [DEC_W-1:0] d;
        d = {$urandom, $urandom, $urandom};
        d[RS_LO +: 5]     = 5'(rs);
        d[RT_LO +: 5]     = 5'(rt);
        d[RD_LO +: 5]     = 5'(rd);
        d[RS_V_BIT]       = rs_v;
        d[RT_V_BIT]       = rt_v;
        d[NPCOP_LO +: 3]  = 3'(npc);
        d[DMWE_BIT]       = dmwe;
        d[RFWE_BIT]       = rfwe;
        d[RFWSRC_LO +: 2] = 2'(src);
        return d;
    endfunction

    function automatic entry_t ent(input logic [DEC_W-1:0] d);
        entry_t e;
        e.pc = next_pc;
        e.dec = d;
        next_pc = next_pc + 32'd4;
        return e;
    endfunction

    function automatic entry_t alu(input int rd, input int rs, input int rt, input bit rt_v);
        return ent(make_dec(rs, rt, rd, 1, rt_v, 0, 0, 1, 0));
    endfunction

    function automatic entry_t rnd_entry();
        int k;
        int a, b, c;
        k = $urandom_range(0, 9);
        a = $urandom_range(0, 7);
        b = $urandom_range(0, 7);
        c = $urandom_range(0, 7);
        if (k <= 4)      return ent(make_dec(a, b, c, 1, $urandom_range(0, 1) == 1, 0, 0, 1, 0));
        else if (k <= 6) return ent(make_dec(a, b, c, 1, 0, 0, 0, 1, 1));
        else if (k <= 8) return ent(make_dec(a, b, 0, 1, 1, 0, 1, 0, 0));
        else             return ent(make_dec(a, b, c, 1, 1, $urandom_range(1, 7), 0,
                                             $urandom_range(0, 1) == 1, 2));
    endfunction

    // Reference rules, stated on whole decode words rather than on the DUT's internals.
    function automatic bit writes_back_from_mem(input logic v, input logic [DEC_W-1:0] d);
        return v && d[RFWE_BIT] && d[RFWSRC_LO +: 2] == 2'd1 && d[RD_LO +: 5] != 5'd0;
    endfunction

    function automatic bit uses(input logic [DEC_W-1:0] d, input logic [4:0] r);
        return (d[RS_V_BIT] && d[RS_LO +: 5] == r) || (d[RT_V_BIT] && d[RT_LO +: 5] == r);
    endfunction

    function automatic bit load_use(input logic [DEC_W-1:0] d);
        bit hz = 0;
        if (writes_back_from_mem(m_v0, m_dec0) && uses(d, m_dec0[RD_LO +: 5])) hz = 1;
        if (writes_back_from_mem(m_v1, m_dec1) && uses(d, m_dec1[RD_LO +: 5])) hz = 1;
        return hz;
    endfunction

    function automatic bit is_memop(input logic [DEC_W-1:0] d);
        return (d[RFWE_BIT] && d[RFWSRC_LO +: 2] == 2'd1) || d[DMWE_BIT];
    endfunction

    function automatic bit pair_ok(input logic [DEC_W-1:0] h, input logic [DEC_W-1:0] n);
        logic [4:0] hrd;
        hrd = h[RD_LO +: 5];
        if (h[RFWE_BIT] && hrd != 5'd0 && uses(n, hrd)) return 0;
        if (h[RFWE_BIT] && n[RFWE_BIT] && hrd == n[RD_LO +: 5]) return 0;
        if (is_memop(h) && is_memop(n)) return 0;
        if (h[NPCOP_LO +: 3] != 3'd0) return 0;
        return 1;
    endfunction

    task automatic model_step(input logic r, input logic f, input logic s, input logic [1:0] c,
                              input entry_t e0, input entry_t e1);
        exp_t x;
        bit rdy, ih, in_;
        bit dual;
`ifdef ISSUE_DUAL_EN
        dual = 1;
`else
        dual = 0;
`endif
        if (r || f) begin
            mq.delete();
            m_v0 = 0;
            m_v1 = 0;
            if (r) begin
                m_pc0 = PC_INITIAL;
                m_dec0 = '0;
                m_pc1 = dual ? PC_INITIAL : '0;
                m_dec1 = '0;
            end
        end else begin
            rdy = (mq.size() <= DEPTH - 2);
            if (!s) begin
                ih  = (mq.size() >= 1) && !load_use(mq[0].dec);
                in_ = dual && ih && (mq.size() >= 2) && !load_use(mq[1].dec)
                      && pair_ok(mq[0].dec, mq[1].dec);
                m_v0 = ih;
                m_v1 = in_;
                if (ih) begin
                    m_pc0 = mq[0].pc;
                    m_dec0 = mq[0].dec;
                    void'(mq.pop_front());
                end
                if (in_) begin
                    m_pc1 = mq[0].pc;
                    m_dec1 = mq[0].dec;
                    void'(mq.pop_front());
                end
            end
            if (rdy && c >= 2'd1) mq.push_back(e0);
            if (rdy && c >= 2'd2) mq.push_back(e1);
        end
        x.v0 = m_v0; x.pc0 = m_pc0; x.dec0 = m_dec0;
        x.v1 = m_v1; x.pc1 = m_pc1; x.dec1 = m_dec1;
        x.rdy = (mq.size() <= DEPTH - 2);
        x.rchk = r;
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic r, input logic f, input logic s, input logic [1:0] c,
                         input entry_t e0, input entry_t e1);
        rst = r; flush = f; stop = s; in_cnt = c;
        in_pc0 = e0.pc; in_dec0 = e0.dec; in_pc1 = e1.pc; in_dec1 = e1.dec;
        model_step(r, f, s, c, e0, e1);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        entry_t z;
        z.pc = '0;
        z.dec = '0;
        for (int i = 0; i < n; i++) drive(0, 0, 0, 2'd0, z, z);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t x;
        bit bad;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                bad = 0;
                if (iss_v0 !== x.v0 || iss_v1 !== x.v1 || in_ready !== x.rdy) bad = 1;
                if (x.v0 && (iss_pc0 !== x.pc0 || iss_dec0 !== x.dec0)) bad = 1;
                if (x.v1 && (iss_pc1 !== x.pc1 || iss_dec1 !== x.dec1)) bad = 1;
                if (x.rchk && (iss_pc0 !== PC_INITIAL || iss_dec0 !== '0)) bad = 1;
`ifdef ISSUE_DUAL_EN
                if (x.rchk && (iss_pc1 !== PC_INITIAL || iss_dec1 !== '0)) bad = 1;
`else
                if (iss_pc1 !== '0 || iss_dec1 !== '0) bad = 1;
`endif
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL issue_out cycle %0d: got v0=%b pc0=%h v1=%b pc1=%h rdy=%b dec0=%h dec1=%h; want v0=%b pc0=%h v1=%b pc1=%h rdy=%b dec0=%h dec1=%h",
                             cyc, iss_v0, iss_pc0, iss_v1, iss_pc1, in_ready, iss_dec0, iss_dec1,
                             x.v0, x.pc0, x.v1, x.pc1, x.rdy, x.dec0, x.dec1);
                end
            end
        end
    end

    initial begin
        entry_t a, b, z;
        int wait_cnt;
        z.pc = '0;
        z.dec = '0;

        drive(1, 0, 0, 2'd0, z, z);
        drive(1, 0, 0, 2'd0, z, z);

        // independent pair
        a = alu(1, 0, 0, 0); b = alu(2, 0, 0, 0);
        drive(0, 0, 0, 2'd2, a, b);
        idle(3);
        // RAW inside the pair
        a = alu(3, 0, 0, 0); b = alu(4, 3, 5, 1);
        drive(0, 0, 0, 2'd2, a, b);
        idle(3);
        // load followed by a consumer
        a = ent(make_dec(0, 0, 6, 1, 0, 0, 0, 1, 1)); b = alu(7, 6, 1, 1);
        drive(0, 0, 0, 2'd2, a, b);
        idle(4);
        // load + store, then branch + alu
        a = ent(make_dec(0, 0, 8, 1, 0, 0, 0, 1, 1)); b = ent(make_dec(9, 10, 0, 1, 1, 0, 1, 0, 0));
        drive(0, 0, 0, 2'd2, a, b);
        idle(3);
        a = ent(make_dec(1, 2, 0, 1, 1, 3, 0, 0, 0)); b = alu(11, 12, 13, 1);
        drive(0, 0, 0, 2'd2, a, b);
        idle(3);
        // fill while stalled, then drain through pointer wrap
        for (int i = 0; i < 4; i++) begin
            a = alu(i + 1, 0, 0, 0); b = alu(i + 10, 0, 0, 0);
            drive(0, 0, 1, 2'd2, a, b);
        end
        for (int i = 0; i < 6; i++) begin
            a = alu(i + 20, 0, 0, 0); b = alu(i + 25, 0, 0, 0);
            drive(0, 0, 0, 2'd2, a, b);
        end
        idle(4);
        // flush while stalled with a partly full queue
        a = alu(1, 0, 0, 0); b = alu(2, 0, 0, 0);
        drive(0, 0, 1, 2'd2, a, b);
        a = alu(3, 0, 0, 0);
        drive(0, 0, 1, 2'd1, a, z);
        a = alu(4, 0, 0, 0);
        drive(0, 1, 1, 2'd1, a, z);
        a = alu(5, 0, 0, 0);
        drive(0, 0, 0, 2'd1, a, z);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            a = rnd_entry();
            b = rnd_entry();
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 4) == 0, 2'($urandom_range(0, 2)), a, b);
        end
        idle(4);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
